// File: rtl/sfx_pkg.sv
`timescale 1ns/1ps
// Shared effect IDs, note record, FSM states and the note ROM for sfx_scheduler.
package sfx_pkg;

   localparam logic [1:0] SFX_FLAP  = 2'd0;
   localparam logic [1:0] SFX_COIN  = 2'd1;
   localparam logic [1:0] SFX_SCORE = 2'd2;
   localparam logic [1:0] SFX_CRASH = 2'd3;

   localparam int unsigned ROM_NOTES = 4;

   typedef struct packed {
      logic [17:0] half_period;
      logic [7:0]  duration;
   } note_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Half-periods in clk cycles (0 = rest), durations in ms (0 = end of effect).
   localparam note_t NOTE_ROM [4][ROM_NOTES] = '{
      '{'{18'd3, 8'd2}, '{18'd0, 8'd1}, '{18'd5, 8'd2}, '{18'd0, 8'd0}},
      '{'{18'd4, 8'd2}, '{18'd2, 8'd3}, '{18'd0, 8'd0}, '{18'd0, 8'd0}},
      '{'{18'd6, 8'd1}, '{18'd5, 8'd1}, '{18'd4, 8'd1}, '{18'd3, 8'd2}},
      '{'{18'd7, 8'd3}, '{18'd9, 8'd3}, '{18'd0, 8'd0}, '{18'd0, 8'd0}}
   };

   function automatic note_t note_lookup(input logic [1:0] id, input int unsigned idx);
      note_t n;
      n = '0;
      if (idx < ROM_NOTES) begin
         n = NOTE_ROM[id][idx[1:0]];
      end else begin
         n = '0;
      end
      return n;
   endfunction

   function automatic logic [7:0] note_duration(input logic [1:0] id, input int unsigned idx);
      logic [7:0] d;
      d = 8'd0;
      if (idx < ROM_NOTES) begin
         d = NOTE_ROM[id][idx[1:0]].duration;
      end else begin
         d = 8'd0;
      end
      return d;
   endfunction

endpackage

// File: rtl/sfx_tone.sv
`timescale 1ns/1ps
// Square-wave generator: toggles audio every half_period cycles while enabled.
module sfx_tone (
   input  logic        clk,
   input  logic        clr,
   input  logic        load,
   input  logic [17:0] half_period,
   input  logic        enable,
   output logic        audio
);

   logic [17:0] cnt_r;
   logic        audio_r;

   // Half-period counter; load, rests and disabled time hold the output low.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_r   <= 18'd0;
         audio_r <= 1'b0;
      end else if (load || !enable || (half_period == 18'd0)) begin
         cnt_r   <= 18'd0;
         audio_r <= 1'b0;
      end else if (cnt_r == (half_period - 18'd1)) begin
         cnt_r   <= 18'd0;
         audio_r <= ~audio_r;
      end else begin
         cnt_r   <= cnt_r + 18'd1;
      end
   end

   assign audio = audio_r;

endmodule

// File: rtl/sfx_scheduler.sv
`timescale 1ns/1ps
// Sound-effect scheduler: latches requests, plays ROM note sequences by priority.
// Optional build macro SFX_PREEMPT_EN lets a higher-priority request abort the playing effect.
module sfx_scheduler #(
   parameter int TICK_DIV  = 100000,
   parameter int MAX_NOTES = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] req,
   input  logic       mute,
   output logic [3:0] ack,
   output logic       busy,
   output logic [1:0] active_id,
   output logic       audio
);
   import sfx_pkg::*;

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IDX_W  = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MAX_NOTES - 1);

   state_t            state_r;
   logic [3:0]        pending_r;
   logic [3:0]        ack_r;
   logic              busy_r;
   logic [1:0]        active_id_r;
   logic [IDX_W-1:0]  idx_r;
   note_t             note_r;
   logic [7:0]        ms_cnt_r;
   logic [TICK_W-1:0] tick_cnt_r;

   logic [3:0]        eff_pend_s;
   logic [1:0]        sel_id_s;
   logic [3:0]        grant_s;
   logic              preempt_s;
   logic              take_s;
   logic              tick_s;
   logic              last_note_s;
   note_t             cur_note_s;
   logic [7:0]        next_dur_s;
   logic              tone_audio_s;

   // Requests arriving this cycle are visible to the arbiter straight away.
   assign eff_pend_s = pending_r | req;

   // Fixed priority: crash > score > coin > flap.
   always_comb begin
      sel_id_s = SFX_FLAP;
      if (eff_pend_s[3]) begin
         sel_id_s = SFX_CRASH;
      end else if (eff_pend_s[2]) begin
         sel_id_s = SFX_SCORE;
      end else if (eff_pend_s[1]) begin
         sel_id_s = SFX_COIN;
      end else begin
         sel_id_s = SFX_FLAP;
      end
   end

   assign grant_s = 4'b0001 << sel_id_s;

`ifdef SFX_PREEMPT_EN
   assign preempt_s = ((state_r == ST_LOAD) || (state_r == ST_PLAY)) &&
                      (|eff_pend_s) && (sel_id_s > active_id_r);
`else
   assign preempt_s = 1'b0;
`endif

   assign take_s = (((state_r == ST_IDLE) || (state_r == ST_DONE)) && (|eff_pend_s)) || preempt_s;

   assign tick_s      = (tick_cnt_r == TICK_LAST);
   assign cur_note_s  = note_lookup(active_id_r, 32'(idx_r));
   assign next_dur_s  = note_duration(active_id_r, 32'(idx_r) + 32'd1);
   assign last_note_s = (idx_r == LAST_IDX) || (next_dur_s == 8'd0);

   // Free-running ms tick divider, never re-aligned to note starts.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         tick_cnt_r <= '0;
      end else if (tick_s) begin
         tick_cnt_r <= '0;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
   end

   // Pending latch: the granted bit clears, same-cycle requests still land.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pending_r <= 4'b0000;
      end else if (take_s) begin
         pending_r <= eff_pend_s & ~grant_s;
      end else begin
         pending_r <= eff_pend_s;
      end
   end

   // Sequencing FSM with registered ack/busy/active_id.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r     <= ST_IDLE;
         ack_r       <= 4'b0000;
         busy_r      <= 1'b0;
         active_id_r <= 2'd0;
         idx_r       <= '0;
         note_r      <= '0;
         ms_cnt_r    <= 8'd0;
      end else begin
         ack_r <= 4'b0000;
         if (take_s) begin
            ack_r       <= grant_s;
            active_id_r <= sel_id_s;
            idx_r       <= '0;
            ms_cnt_r    <= 8'd0;
            busy_r      <= 1'b1;
            state_r     <= ST_LOAD;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  busy_r <= 1'b0;
               end
               ST_LOAD: begin
                  note_r   <= cur_note_s;
                  ms_cnt_r <= 8'd0;
                  if (cur_note_s.duration == 8'd0) begin
                     state_r <= ST_DONE;
                  end else begin
                     state_r <= ST_PLAY;
                  end
               end
               ST_PLAY: begin
                  if (tick_s) begin
                     if ((ms_cnt_r + 8'd1) >= note_r.duration) begin
                        ms_cnt_r <= 8'd0;
                        if (last_note_s) begin
                           state_r <= ST_DONE;
                        end else begin
                           idx_r   <= idx_r + IDX_W'(1);
                           state_r <= ST_LOAD;
                        end
                     end else begin
                        ms_cnt_r <= ms_cnt_r + 8'd1;
                     end
                  end
               end
               ST_DONE: begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
               default: begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   sfx_tone u_tone (
      .clk         (clk),
      .clr         (clr),
      .load        (state_r == ST_LOAD),
      .half_period (note_r.half_period),
      .enable      (state_r == ST_PLAY),
      .audio       (tone_audio_s)
   );

   assign ack       = ack_r;
   assign busy      = busy_r;
   assign active_id = active_id_r;
   // Mute only gates the pin; sequencing is untouched.
   assign audio     = tone_audio_s & ~mute;

endmodule

// File: tb/tb_sfx_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for sfx_scheduler: stimulus queues expected ack IDs, a monitor checks every ack pulse.
module tb_sfx_scheduler;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       mute = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] ack;
   logic       busy;
   logic [1:0] active_id;
   logic       audio;

   sfx_scheduler #(.TICK_DIV(10), .MAX_NOTES(4)) dut (
      .clk       (clk),
      .clr       (clr),
      .req       (req),
      .mute      (mute),
      .ack       (ack),
      .busy      (busy),
      .active_id (active_id),
      .audio     (audio)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int last_ack_cyc[4];
   int ack_count = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Monitor: every ack pulse must match the next queued effect.
   always @(negedge clk) begin
      if (ack != 4'b0000) begin
         ack_count++;
         for (int i = 0; i < 4; i++) if (ack[i]) last_ack_cyc[i] = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack: got ack=%b, expected none", ack);
         end else begin
            int e;
            e = exp_q.pop_front();
            check("ack_id", int'(ack), 1 << e);
            check("active_id", int'(active_id), e);
         end
      end
   end

   task automatic pulse(input logic [3:0] mask, output int pc);
      @(posedge clk); #1;
      req = mask;
      pc = cyc;
      @(posedge clk); #1;
      req = 4'b0000;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 500 && !done; k++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check(name, int'(done), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic watch(input int p, output int ack_d, output int rise_d, output int hi_w,
                        output int lo_w, output int highs, output int blen, output int ok);
      int a, r1, f1, r2;
      bit prev, seen, done;
      a = -1; r1 = -1; f1 = -1; r2 = -1;
      prev = 1'b0; seen = 1'b0; done = 1'b0;
      highs = 0; blen = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (ack[0] && a < 0) a = cyc;
         if (busy) begin
            seen = 1'b1;
            blen++;
         end else if (seen) begin
            done = 1'b1;
         end
         if (audio) highs++;
         if (audio && !prev) begin
            if (r1 < 0) r1 = cyc;
            else if (r2 < 0) r2 = cyc;
         end
         if (!audio && prev && f1 < 0) f1 = cyc;
         prev = audio;
      end
      ok = int'(done);
      ack_d = a - p;
      rise_d = r1 - a;
      hi_w = f1 - r1;
      lo_w = r2 - f1;
   endtask

   initial begin
      int p, ad, rd, hw, lw, hi, bl, ok, a1, snap;

      repeat (3) @(negedge clk);
      check("rst_ack", int'(ack), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_active_id", int'(active_id), 0);
      check("rst_audio", int'(audio), 0);
      @(posedge clk); #1;
      clr = 1'b1;
      repeat (5) @(posedge clk);

      // Single flap: note 0 has half-period 3, effect lasts 2+1+2 ms.
      exp_q.push_back(0);
      pulse(4'b0001, p);
      watch(p, ad, rd, hw, lw, hi, bl, ok);
      check("flap_done", ok, 1);
      check("flap_ack_delay", ad, 1);
      check("flap_first_rise", rd, 4);
      check("flap_high_width", hw, 3);
      check("flap_low_width", lw, 3);
      check_range("flap_busy_len", bl, 40, 60);
      wait_idle("flap_idle");

      // Flap and crash together: crash first, flap after crash completes.
      exp_q.push_back(3);
      exp_q.push_back(0);
      pulse(4'b1001, p);
      wait_idle("simul_idle");
      check("simul_crash_delay", last_ack_cyc[3] - p, 1);
      check_range("simul_flap_after_crash", last_ack_cyc[0] - last_ack_cyc[3], 50, 70);

      // Score requested while coin plays.
      exp_q.push_back(1);
      pulse(4'b0010, p);
      a1 = p + 1;
      repeat (20) @(negedge clk);
      check("coin_busy", int'(busy), 1);
      exp_q.push_back(2);
      pulse(4'b0100, p);
      wait_idle("preempt_idle");
`ifdef SFX_PREEMPT_EN
      check("score_preempt_delay", last_ack_cyc[2] - p, 1);
`else
      check_range("score_after_coin", last_ack_cyc[2] - a1, 40, 60);
`endif

      // Coin re-requested while playing: replayed after completion.
      exp_q.push_back(1);
      exp_q.push_back(1);
      pulse(4'b0010, p);
      repeat (15) @(negedge clk);
      a1 = last_ack_cyc[1];
      check("replay_first_delay", a1 - p, 1);
      pulse(4'b0010, p);
      wait_idle("replay_idle");
      check_range("replay_gap", last_ack_cyc[1] - a1, 40, 60);

      // Reset mid-play abandons the effect and drops requests seen during reset.
      exp_q.push_back(3);
      pulse(4'b1000, p);
      repeat (20) @(negedge clk);
      check("pre_reset_busy", int'(busy), 1);
      @(posedge clk); #1;
      clr = 1'b0;
      req = 4'b0100;
      @(negedge clk);
      check("reset_audio", int'(audio), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_ack", int'(ack), 0);
      check("reset_active_id", int'(active_id), 0);
      @(posedge clk); #1;
      req = 4'b0000;
      @(posedge clk); #1;
      clr = 1'b1;
      snap = ack_count;
      repeat (100) @(negedge clk);
      check("no_ack_after_reset", ack_count - snap, 0);
      check("busy_after_reset", int'(busy), 0);

      // Muted flap: silent, same ack/busy behaviour.
      mute = 1'b1;
      exp_q.push_back(0);
      pulse(4'b0001, p);
      watch(p, ad, rd, hw, lw, hi, bl, ok);
      check("mute_done", ok, 1);
      check("mute_ack_delay", ad, 1);
      check("mute_audio_highs", hi, 0);
      check_range("mute_busy_len", bl, 40, 60);
      mute = 1'b0;
      wait_idle("mute_idle");

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick.
REQ-002 SHALL have parameter MAX_NOTES, default 4, notes per effect.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz).
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  effect request pulses: bit0 flap, bit1 coin, bit2 score, bit3 crash.
REQ-006 SHALL have port mute  input  1  forces audio low; sequencing continues.
REQ-007 SHALL have port ack  output  4  one-cycle pulse when the matching effect starts playing.
REQ-008 SHALL have port busy  output  1  high while an effect plays.
REQ-009 SHALL have port active_id  output  2  index of the effect currently playing.
REQ-010 SHALL have port audio  output  1  square-wave buzzer drive.

Function
REQ-011 SHALL OR each req bit into a 4-bit pending register every cycle; pending bit clears when that effect gets ack.
REQ-012 SHALL use fixed priority crash(3) > score(2) > coin(1) > flap(0).
REQ-013 SHALL run FSM IDLE -> LOAD -> PLAY -> (LOAD next note | DONE) ; DONE -> LOAD if any pending else IDLE.
REQ-014 IDLE: with any pending bit set, SHALL select highest pending, pulse ack, enter LOAD next cycle.
REQ-015 LOAD: SHALL fetch note[idx] (18-bit half-period, 8-bit duration in ms) in one cycle, then enter PLAY.
REQ-016 PLAY: SHALL toggle audio every half-period cycles; half-period 0 means rest (audio low).
REQ-017 PLAY: SHALL count ms ticks; when count reaches duration, go to LOAD with idx+1, or DONE if idx = MAX_NOTES-1 or next duration is 0.
REQ-018 Duration 0 on note 0 SHALL make the effect end immediately, with ack still pulsed.
REQ-019 A request for the effect already playing SHALL set pending and replay it after completion, not restart it.
REQ-020 Simultaneous requests in one cycle SHALL all latch; they are served in priority order, one per completion.
REQ-021 busy SHALL be high in LOAD, PLAY and DONE; active_id SHALL hold its value until the next ack.
REQ-022 The ms tick counter SHALL free-run, so the first note duration may be up to 1 tick short.
REQ-023 mute SHALL gate audio combinationally after the register, with no effect on timing or ack.

Reset
REQ-024 With clr low, SHALL force FSM to IDLE, pending=0, ack=0, busy=0, active_id=0, audio=0, all counters 0.
REQ-025 Reset mid-effect SHALL abandon the effect without ack; requests during reset SHALL be lost.

Configuration
REQ-026 Macro SFX_PREEMPT_EN defined: a pending effect of higher priority than active_id SHALL abort PLAY/LOAD the next cycle, get ack, and start at note 0; the aborted effect is not resumed.
REQ-027 SFX_PREEMPT_EN undefined: effects SHALL always run to completion before the next is served.

Structure
REQ-028 Package sfx_pkg SHALL hold effect ID constants, note record type (half-period, duration), note ROM table [4][MAX_NOTES], and FSM state enum.
REQ-029 Sub-module sfx_tone SHALL implement the half-period counter and audio toggle (load, half_period, enable in; audio out).

Verification (TICK_DIV=10 for sim)
REQ-030 Single flap pulse from IDLE -> ack[0] next cycle; busy high; audio edges match ROM half-periods; busy low after sum of durations x 10 cycles (+/-10).
REQ-031 flap and crash pulsed in the same cycle -> ack[3] first, active_id=3; ack[0] after crash completes.
REQ-032 With SFX_PREEMPT_EN, coin playing and score pulsed -> ack[2] within 1 cycle and coin is not resumed; without the macro, score is acked only after coin's DONE.
REQ-033 coin re-pulsed while coin plays -> coin plays twice back to back, with two ack[1] pulses.
REQ-034 clr asserted mid-PLAY -> audio=0, busy=0, pending=0 immediately; no ack after release until a new req.
REQ-035 mute held through a flap -> audio stays 0; ack and busy timing identical to REQ-030.
